// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a clock-enable divider produces the pixel tick,
// and horizontal/vertical counters advance on that tick to drive sync, blanking and strobes.
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_tick,
    output logic [CW-1:0] hCount,
    output logic [CW-1:0] vCount,
    output logic          hSync,
    output logic          vSync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic POL   = (SYNC_POL != 0);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Decode bounds carry one extra bit so an end-of-sync equal to the total cannot wrap.
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;

    assign pix_tick    = en && !reset && (div_cnt == DIV_LAST);
    assign line_start  = pix_tick && (hCount == H_LAST);
    assign frame_start = line_start && (vCount == V_LAST);

    assign h_ext = {1'b0, hCount};
    assign v_ext = {1'b0, vCount};

    always_comb begin
        hSync    = ~POL;
        vSync    = ~POL;
        video_on = 1'b0;
        if (h_ext >= H_SYNC_BEG && h_ext < H_SYNC_END)
            hSync = POL;
        if (v_ext >= V_SYNC_BEG && v_ext < V_SYNC_END)
            vSync = POL;
        if (h_ext < H_ACT_END && v_ext < V_ACT_END)
            video_on = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            hCount      <= '0;
            vCount      <= '0;
            frame_count <= '0;
        end else begin
            if (en)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (pix_tick) begin
                if (hCount == H_LAST) begin
                    hCount <= '0;
                    vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
                end else begin
                    hCount <= hCount + 1'b1;
                end
                if (frame_start)
                    frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator for the Nexys4 display path. It divides the board clock internally into a pixel tick and runs horizontal and vertical counters from that tick. It produces sync pulses with configurable porches and polarity, a visible-area flag, line and frame strobes, and a frame counter. Sprite and tile renderers consume hCount, vCount and video_on.

Parameters:
DIV, 4, board clocks per pixel tick (>=1); 4 gives 25 MHz from 100 MHz
CW, 10, width of hCount and vCount
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hSync and vSync (0 = active-low)

Ports:
clk  input  1  board clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
en  input  1  run enable; when low, the divider and counters freeze
pix_tick  output  1  one-clk pulse per pixel period
hCount  output  CW  horizontal position, 0..H_TOTAL-1
vCount  output  CW  vertical position, 0..V_TOTAL-1
hSync  output  1  horizontal sync
vSync  output  1  vertical sync
video_on  output  1  high inside the visible area
line_start  output  1  one-clk strobe on the tick that ends a line
frame_start  output  1  one-clk strobe on the tick that ends a frame
frame_count  output  8  completed-frame counter

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). H_TOTAL-1 and V_TOTAL-1 must each fit in CW bits.
- Divider: internal counter div_cnt runs 0..DIV-1 and advances only while en=1.
  - pix_tick = en && (div_cnt == DIV-1).
  - With DIV=1, pix_tick equals en.
  - No derived clocks; everything is clocked by clk.
- Counters: update only on clk edges where pix_tick=1.
  - hCount<H_TOTAL-1: hCount+1.
  - hCount==H_TOTAL-1: hCount to 0; vCount+1, or vCount to 0 if vCount==V_TOTAL-1.
- Line order is active, front porch, sync, back porch. The same order applies to lines.
- Decodes are combinational on the registered counters, so they align with hCount and vCount in the same cycle:
  - hSync = SYNC_POL when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL. Default: low for hCount 656..751.
  - vSync = SYNC_POL when V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC; otherwise ~SYNC_POL. Default: low for vCount 490..491.
  - video_on = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
  - line_start = pix_tick && hCount==H_TOTAL-1.
  - frame_start = line_start && vCount==V_TOTAL-1.
- frame_count increments on every frame_start. It wraps 255->0.
- Reset (synchronous, highest priority, any time including mid-frame):
  - div_cnt=0, hCount=0, vCount=0, frame_count=0.
  - pix_tick, line_start and frame_start are 0 while reset is high.
  - hSync and vSync follow the decode, so they sit at the inactive level.
  - video_on=1 per decode at (0,0); downstream gates pixels with its own reset.
  - The first pix_tick comes DIV clk edges after reset is released with en=1.
- en low: div_cnt, hCount, vCount and frame_count hold. Strobes are 0. Sync levels and video_on hold their decoded values.
- en high again: counting resumes from the held div_cnt, with no lost or extra tick.
- Simultaneous reset and en: reset wins.

Test Plan:
- Reset and release, defaults, en=1: pix_tick first high on the 4th clk after release, then every 4 clks. hCount 0->1 on the first tick. hSync=1, vSync=1, video_on=1 at (0,0).
- Horizontal timing: run one line. hSync is low exactly while hCount=656..751. video_on falls when hCount=640. line_start is a single clk at hCount=799 with pix_tick. The next tick gives hCount=0 and vCount=1.
- Frame wrap: run to (799,524). frame_start and line_start pulse together. The next tick gives (0,0) and frame_count 0->1. vSync is low only for vCount=490..491. Over a full frame there are 525 line_start pulses and 420000 pix_ticks.
- en freeze: drop en for 37 clks mid-line at hCount=300. hCount, div_cnt and outputs hold, with no strobes. After re-enable, the tick spacing remains exactly 4 clks including the resume.
- Mid-frame reset at (700,491) while vSync is low: on the next edge the counters are 0, vSync=1 and frame_count=0. The first tick comes 4 clks after release.
- Override DIV=1, H=4/1/2/1, V=3/1/1/1, SYNC_POL=1: pix_tick equals en, H_TOTAL=8, V_TOTAL=6. hSync is high at hCount=5..6 and vSync is high at vCount=4. frame_start fires every 48 clks. frame_count wraps 255->0 after 256 frames.
